// File: rtl/obi_mem_arbiter_if.sv
// Bus bundle for obi_mem_arbiter: instruction port, data port and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding core/memory.
interface obi_mem_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        protocol_err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output protocol_err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  protocol_err_o
    );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Two-master (instr/data) to one-slave OBI arbiter with a sticky arbitration lock
// and an in-order ID FIFO that steers each response back to its issuer.
module obi_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          DATA_PRIO       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    obi_mem_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic ID_INSTR = 1'b0;
    localparam logic ID_DATA  = 1'b1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] fifo_r;
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       lock_r;
    logic                       lock_id_r;
    logic                       last_r;
    logic                       protocol_err_r;

    logic winner_s;
    logic win_req_s;
    logic mem_req_s;
    logic accept_s;
    logic pop_s;
    logic orphan_s;
    logic head_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = ptr + PTR_W'(1'b1);
        end
    endfunction

    // Winner selection: a pending (locked) request is never preempted.
    always_comb begin
        winner_s = ID_INSTR;
        if (lock_r) begin
            winner_s = lock_id_r;
        end else if (bus.data_req_i && bus.instr_req_i) begin
            winner_s = DATA_PRIO ? ID_DATA : ~last_r;
        end else if (bus.data_req_i) begin
            winner_s = ID_DATA;
        end else begin
            winner_s = ID_INSTR;
        end
    end

    // Request gating against FIFO occupancy and response bookkeeping.
    always_comb begin
        win_req_s = winner_s ? bus.data_req_i : bus.instr_req_i;
        mem_req_s = win_req_s && (count_r < CNT_MAX);
        accept_s  = mem_req_s && bus.mem_gnt_i;
        pop_s     = bus.mem_rvalid_i && (count_r != {CNT_W{1'b0}});
        orphan_s  = bus.mem_rvalid_i && (count_r == {CNT_W{1'b0}});
        head_s    = fifo_r[rd_ptr_r];
    end

    // Fields are zeroed when the winner is not requesting so an idle port is quiet.
    assign bus.mem_req_o   = mem_req_s;
    assign bus.mem_we_o    = win_req_s & winner_s & bus.data_we_i;
    assign bus.mem_be_o    = !win_req_s ? 4'h0 : (winner_s ? bus.data_be_i : 4'hF);
    assign bus.mem_addr_o  = !win_req_s ? 32'h0 : (winner_s ? bus.data_addr_i : bus.instr_addr_i);
    assign bus.mem_wdata_o = (win_req_s && winner_s) ? bus.data_wdata_i : 32'h0;

    assign bus.instr_gnt_o    = accept_s & ~winner_s;
    assign bus.data_gnt_o     = accept_s & winner_s;
    assign bus.instr_rvalid_o = pop_s & ~head_s;
    assign bus.data_rvalid_o  = pop_s & head_s;
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;
    assign bus.instr_err_o    = bus.mem_err_i & pop_s & ~head_s;
    assign bus.data_err_o     = bus.mem_err_i & pop_s & head_s;
    assign bus.protocol_err_o = protocol_err_r;

    // ID FIFO, occupancy, lock, round-robin pointer and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_r         <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {CNT_W{1'b0}};
            lock_r         <= 1'b0;
            lock_id_r      <= ID_INSTR;
            last_r         <= ID_INSTR;
            protocol_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                fifo_r[wr_ptr_r] <= winner_s;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
                last_r           <= winner_s;
                lock_r           <= 1'b0;
            end else if (mem_req_s) begin
                lock_r    <= 1'b1;
                lock_id_r <= winner_s;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
            if (orphan_s) begin
                protocol_err_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: a fixed-priority (depth 2) and a round-robin (depth 3) instance
// share stimulus and are compared against a queue-based reference model.
module tb_obi_mem_arbiter;
    localparam int MAX_FP = 2;
    localparam int MAX_RR = 3;
    localparam int VW     = 141;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int n_checks = 0;
    int n_errors = 0;

    bit q_fp[$];
    bit q_rr[$];
    bit m_lock[2];
    bit m_lock_id[2];
    bit m_last[2];
    bit m_perr[2];

    always #5 clk = ~clk;

    obi_mem_arbiter_if fp_if ();
    obi_mem_arbiter_if rr_if ();

    obi_mem_arbiter #(.MAX_OUTSTANDING(MAX_FP), .DATA_PRIO(1'b1)) u_fp (.clk(clk), .rst(rst), .bus(fp_if.slave));
    obi_mem_arbiter #(.MAX_OUTSTANDING(MAX_RR), .DATA_PRIO(1'b0)) u_rr (.clk(clk), .rst(rst), .bus(rr_if.slave));

    assign fp_if.instr_req_i  = instr_req;
    assign fp_if.instr_addr_i = instr_addr;
    assign fp_if.data_req_i   = data_req;
    assign fp_if.data_we_i    = data_we;
    assign fp_if.data_be_i    = data_be;
    assign fp_if.data_addr_i  = data_addr;
    assign fp_if.data_wdata_i = data_wdata;
    assign fp_if.mem_gnt_i    = mem_gnt;
    assign fp_if.mem_rvalid_i = mem_rvalid;
    assign fp_if.mem_rdata_i  = mem_rdata;
    assign fp_if.mem_err_i    = mem_err;
    assign rr_if.instr_req_i  = instr_req;
    assign rr_if.instr_addr_i = instr_addr;
    assign rr_if.data_req_i   = data_req;
    assign rr_if.data_we_i    = data_we;
    assign rr_if.data_be_i    = data_be;
    assign rr_if.data_addr_i  = data_addr;
    assign rr_if.data_wdata_i = data_wdata;
    assign rr_if.mem_gnt_i    = mem_gnt;
    assign rr_if.mem_rvalid_i = mem_rvalid;
    assign rr_if.mem_rdata_i  = mem_rdata;
    assign rr_if.mem_err_i    = mem_err;

    logic [VW-1:0] act_fp;
    logic [VW-1:0] act_rr;
    assign act_fp = {fp_if.mem_req_o, fp_if.mem_we_o, fp_if.mem_be_o, fp_if.mem_addr_o, fp_if.mem_wdata_o,
                     fp_if.instr_gnt_o, fp_if.data_gnt_o, fp_if.instr_rvalid_o, fp_if.data_rvalid_o,
                     fp_if.instr_err_o, fp_if.data_err_o, fp_if.instr_rdata_o, fp_if.data_rdata_o,
                     fp_if.protocol_err_o};
    assign act_rr = {rr_if.mem_req_o, rr_if.mem_we_o, rr_if.mem_be_o, rr_if.mem_addr_o, rr_if.mem_wdata_o,
                     rr_if.instr_gnt_o, rr_if.data_gnt_o, rr_if.instr_rvalid_o, rr_if.data_rvalid_o,
                     rr_if.instr_err_o, rr_if.data_err_o, rr_if.instr_rdata_o, rr_if.data_rdata_o,
                     rr_if.protocol_err_o};

    // ---------------- reference model (k = 0: fixed priority, k = 1: round robin) ----------------
    function automatic int q_size(int k);
        return (k == 0) ? q_fp.size() : q_rr.size();
    endfunction

    function automatic int q_max(int k);
        return (k == 0) ? MAX_FP : MAX_RR;
    endfunction

    function automatic bit mdl_winner(int k);
        if (m_lock[k]) return m_lock_id[k];
        if (instr_req && data_req) return (k == 0) ? 1'b1 : ~m_last[k];
        return data_req;
    endfunction

    function automatic logic [VW-1:0] exp_vec(int k);
        bit w, wreq, mreq, gnt, hd, irv, drv;
        logic [3:0] be;
        logic [31:0] addr, wdata;
        w     = mdl_winner(k);
        wreq  = w ? data_req : instr_req;
        mreq  = wreq && (q_size(k) < q_max(k));
        gnt   = mreq && mem_gnt;
        hd    = 1'b0;
        if (q_size(k) > 0) hd = (k == 0) ? q_fp[0] : q_rr[0];
        irv   = mem_rvalid && (q_size(k) > 0) && !hd;
        drv   = mem_rvalid && (q_size(k) > 0) && hd;
        be    = !wreq ? 4'h0 : (w ? data_be : 4'hF);
        addr  = !wreq ? 32'h0 : (w ? data_addr : instr_addr);
        wdata = (wreq && w) ? data_wdata : 32'h0;
        return {mreq, wreq && w && data_we, be, addr, wdata, gnt && !w, gnt && w, irv, drv,
                irv && mem_err, drv && mem_err, mem_rdata, mem_rdata, m_perr[k]};
    endfunction

    function automatic void mdl_step();
        bit w, wreq, mreq;
        for (int k = 0; k < 2; k++) begin
            w    = mdl_winner(k);
            wreq = w ? data_req : instr_req;
            mreq = wreq && (q_size(k) < q_max(k));
            if (mem_rvalid) begin
                if (q_size(k) == 0) m_perr[k] = 1'b1;
                else if (k == 0) void'(q_fp.pop_front());
                else void'(q_rr.pop_front());
            end
            if (mreq && mem_gnt) begin
                if (k == 0) q_fp.push_back(w); else q_rr.push_back(w);
                m_last[k] = w;
                m_lock[k] = 1'b0;
            end else if (mreq) begin
                m_lock[k]    = 1'b1;
                m_lock_id[k] = w;
            end
        end
    endfunction

    function automatic void mdl_reset();
        q_fp.delete();
        q_rr.delete();
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 1'b0; m_lock_id[k] = 1'b0; m_last[k] = 1'b0; m_perr[k] = 1'b0;
        end
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic drive_idle();
        instr_req = 1'b0; instr_addr = 32'h0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0; mem_err = 1'b0;
    endtask

    task automatic advance();
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_reset();
    endtask

    task automatic drain();
        drive_idle();
        for (int i = 0; i < 16 && q_fp.size() > 0; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            advance();
        end
        drive_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mdl_reset();
        @(negedge clk);
        n_checks++;
        if (act_fp !== {VW{1'b0}}) begin n_errors++; $display("FAIL reset_fp got=%h want=0", act_fp); end
        n_checks++;
        if (act_rr !== {VW{1'b0}}) begin n_errors++; $display("FAIL reset_rr got=%h want=0", act_rr); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fixed_prio();
        instr_req = 1'b1; instr_addr = 32'h0000_1000;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'h3; data_addr = 32'h0000_2000; data_wdata = 32'hCAFE_0001;
        mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fp_if.data_gnt_o, fp_if.instr_gnt_o} !== 2'b10) begin
            n_errors++; $display("FAIL prio_gnt got=%b want=10", {fp_if.data_gnt_o, fp_if.instr_gnt_o});
        end
        n_checks++;
        if (fp_if.mem_addr_o !== 32'h0000_2000) begin
            n_errors++; $display("FAIL prio_addr got=%h want=00002000", fp_if.mem_addr_o);
        end
        n_checks++;
        if (act_rr !== exp_vec(1)) begin n_errors++; $display("FAIL prio_rr_vec got=%h want=%h", act_rr, exp_vec(1)); end
        advance();
        data_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fp_if.instr_gnt_o, fp_if.mem_be_o, fp_if.mem_we_o, fp_if.mem_addr_o} !== {1'b1, 4'hF, 1'b0, 32'h0000_1000}) begin
            n_errors++; $display("FAIL prio_instr_next got=%b/%h/%b/%h want=1/f/0/00001000",
                fp_if.instr_gnt_o, fp_if.mem_be_o, fp_if.mem_we_o, fp_if.mem_addr_o);
        end
        advance();
        drive_idle();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++;
        if ({fp_if.data_rvalid_o, fp_if.instr_rvalid_o, fp_if.data_rdata_o} !== {2'b10, 32'h1111_2222}) begin
            n_errors++; $display("FAIL prio_resp1 got=%b%b/%h want=10/11112222",
                fp_if.data_rvalid_o, fp_if.instr_rvalid_o, fp_if.data_rdata_o);
        end
        advance();
        mem_rdata = 32'h3333_4444;
        @(negedge clk);
        n_checks++;
        if ({fp_if.data_rvalid_o, fp_if.instr_rvalid_o, fp_if.instr_rdata_o} !== {2'b01, 32'h3333_4444}) begin
            n_errors++; $display("FAIL prio_resp2 got=%b%b/%h want=01/33334444",
                fp_if.data_rvalid_o, fp_if.instr_rvalid_o, fp_if.instr_rdata_o);
        end
        advance();
        drive_idle();
    endtask

    task automatic test_lock();
        instr_req = 1'b1; instr_addr = 32'hA000_0000; data_addr = 32'hD000_0000; data_be = 4'h1;
        for (int i = 0; i < 3; i++) begin
            data_req = (i == 2);
            @(negedge clk);
            n_checks++;
            if ({fp_if.mem_req_o, fp_if.instr_gnt_o, fp_if.data_gnt_o, fp_if.mem_addr_o} !== {3'b100, 32'hA000_0000}) begin
                n_errors++; $display("FAIL lock_hold[%0d] got=%b%b%b/%h want=100/a0000000", i,
                    fp_if.mem_req_o, fp_if.instr_gnt_o, fp_if.data_gnt_o, fp_if.mem_addr_o);
            end
            advance();
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fp_if.instr_gnt_o, fp_if.data_gnt_o, fp_if.mem_addr_o} !== {2'b10, 32'hA000_0000}) begin
            n_errors++; $display("FAIL lock_gnt got=%b%b/%h want=10/a0000000",
                fp_if.instr_gnt_o, fp_if.data_gnt_o, fp_if.mem_addr_o);
        end
        n_checks++;
        if (act_rr !== exp_vec(1)) begin n_errors++; $display("FAIL lock_rr_vec got=%h want=%h", act_rr, exp_vec(1)); end
        advance();
        instr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fp_if.instr_gnt_o, fp_if.data_gnt_o, fp_if.mem_addr_o} !== {2'b01, 32'hD000_0000}) begin
            n_errors++; $display("FAIL lock_then_data got=%b%b/%h want=01/d0000000",
                fp_if.instr_gnt_o, fp_if.data_gnt_o, fp_if.mem_addr_o);
        end
        advance();
        drain();
    endtask

    task automatic test_full();
        instr_req = 1'b1; instr_addr = 32'h0000_0400; mem_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (fp_if.instr_gnt_o !== 1'b1) begin n_errors++; $display("FAIL full_fill[%0d] gnt got=%b want=1", i, fp_if.instr_gnt_o); end
            advance();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({fp_if.mem_req_o, fp_if.instr_gnt_o, fp_if.data_gnt_o} !== 3'b000) begin
            n_errors++; $display("FAIL full_block got=%b%b%b want=000", fp_if.mem_req_o, fp_if.instr_gnt_o, fp_if.data_gnt_o);
        end
        n_checks++;
        if ({fp_if.instr_rvalid_o, fp_if.instr_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL full_resp got=%b/%h want=1/deadbeef", fp_if.instr_rvalid_o, fp_if.instr_rdata_o);
        end
        advance();
        mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fp_if.mem_req_o, fp_if.instr_gnt_o} !== 2'b11) begin
            n_errors++; $display("FAIL full_release got=%b%b want=11", fp_if.mem_req_o, fp_if.instr_gnt_o);
        end
        n_checks++;
        if (act_rr !== exp_vec(1)) begin n_errors++; $display("FAIL full_rr_vec got=%h want=%h", act_rr, exp_vec(1)); end
        advance();
        drain();
    endtask

    task automatic test_err();
        data_req = 1'b1; data_addr = 32'h0000_0800; data_be = 4'hF; mem_gnt = 1'b1;
        advance();
        data_req = 1'b0; instr_req = 1'b1; instr_addr = 32'h0000_0C00;
        advance();
        drive_idle();
        mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        n_checks++;
        if ({fp_if.data_rvalid_o, fp_if.data_err_o, fp_if.instr_rvalid_o, fp_if.instr_err_o} !== 4'b1100) begin
            n_errors++; $display("FAIL err_data got=%b%b%b%b want=1100",
                fp_if.data_rvalid_o, fp_if.data_err_o, fp_if.instr_rvalid_o, fp_if.instr_err_o);
        end
        advance();
        mem_err = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fp_if.data_rvalid_o, fp_if.data_err_o, fp_if.instr_rvalid_o, fp_if.instr_err_o} !== 4'b0010) begin
            n_errors++; $display("FAIL err_instr got=%b%b%b%b want=0010",
                fp_if.data_rvalid_o, fp_if.data_err_o, fp_if.instr_rvalid_o, fp_if.instr_err_o);
        end
        n_checks++;
        if (act_rr !== exp_vec(1)) begin n_errors++; $display("FAIL err_rr_vec got=%h want=%h", act_rr, exp_vec(1)); end
        advance();
        drive_idle();
    endtask

    task automatic test_round_robin();
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h0000_0100; data_req = 1'b1; data_addr = 32'h0000_0200;
        data_be = 4'hF; mem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = (i > 0);
            @(negedge clk);
            n_checks++;
            if ({rr_if.data_gnt_o, rr_if.instr_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_errors++; $display("FAIL rr_gnt[%0d] got=%b%b want=%s", i, rr_if.data_gnt_o, rr_if.instr_gnt_o,
                    (i % 2 == 0) ? "10" : "01");
            end
            if (i > 0) begin
                n_checks++;
                if ({rr_if.data_rvalid_o, rr_if.instr_rvalid_o} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_errors++; $display("FAIL rr_resp[%0d] got=%b%b", i, rr_if.data_rvalid_o, rr_if.instr_rvalid_o);
                end
            end
            advance();
        end
        drain();
    endtask

    task automatic test_protocol_err();
        drive_idle();
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        n_checks++;
        if ({fp_if.instr_rvalid_o, fp_if.data_rvalid_o, fp_if.protocol_err_o} !== 3'b000) begin
            n_errors++; $display("FAIL perr_drop got=%b%b%b want=000",
                fp_if.instr_rvalid_o, fp_if.data_rvalid_o, fp_if.protocol_err_o);
        end
        advance();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({fp_if.protocol_err_o, rr_if.protocol_err_o} !== 2'b11) begin
                n_errors++; $display("FAIL perr_sticky[%0d] got=%b%b want=11", i, fp_if.protocol_err_o, rr_if.protocol_err_o);
            end
            advance();
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({fp_if.protocol_err_o, rr_if.protocol_err_o} !== 2'b00) begin
            n_errors++; $display("FAIL perr_clear got=%b%b want=00", fp_if.protocol_err_o, rr_if.protocol_err_o);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            instr_req  = ($urandom_range(0, 3) != 0);
            instr_addr = $urandom;
            data_req   = ($urandom_range(0, 2) != 0);
            data_we    = $urandom_range(0, 1);
            data_be    = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
            mem_gnt    = ($urandom_range(0, 2) != 0);
            if (q_fp.size() > 0 && q_rr.size() > 0) mem_rvalid = $urandom_range(0, 1);
            else mem_rvalid = ($urandom_range(0, 199) == 0);
            mem_rdata  = $urandom;
            mem_err    = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n_checks++;
            if (act_fp !== exp_vec(0)) begin
                n_errors++;
                if (shown < 10) $display("FAIL rand_fp[%0d] got=%h want=%h", i, act_fp, exp_vec(0));
                shown++;
            end
            n_checks++;
            if (act_rr !== exp_vec(1)) begin
                n_errors++;
                if (shown < 10) $display("FAIL rand_rr[%0d] got=%h want=%h", i, act_rr, exp_vec(1));
                shown++;
            end
            advance();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        mdl_reset();
        test_reset();
        test_fixed_prio();
        test_lock();
        test_full();
        test_err();
        test_round_robin();
        test_protocol_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
